// File: rtl/l1d_axi_master.sv
// l1d_axi_master
// Turns the L1 data cache's memory-side requests into AXI4 transactions on
// data master port 1:
//   - a read miss becomes a 4-beat INCR line fill;
//   - a write-through store becomes a single-beat write with byte strobes.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   d_req/d_addr/d_write/d_in/d_type
//                      cache request, held by the cache until completion;
//                      d_type is active-low byte enables
//   d_out              read beat data (RDATA pass-through)
//   rvalid_o, rready_o R channel handshake mirrors for the cache
//   wr_done            one-cycle pulse on the B handshake
//   bus_err            sticky response error flag
//   ar*/r*/aw*/w*/b*   AXI4 master channels
//
// Configuration
//   L1D_AXI_ERR_FLAG_EN  when defined, bus_err latches any non-OKAY
//                        RRESP/BRESP or an RID/BID that differs from AXI_ID.
//                        When undefined, bus_err is tied low and no check
//                        logic exists.

module l1d_axi_master #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // cache side
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_in,
  input  logic [3:0]  d_type,
  output logic [31:0] d_out,
  output logic        rvalid_o,
  output logic        rready_o,
  output logic        wr_done,
  output logic        bus_err,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  logic [2:0]  state;
  logic [31:0] addr_r;
  logic [31:0] din_r;
  logic [3:0]  type_r;
  logic [1:0]  beat_cnt;

  logic r_hs;
  logic b_hs;

  assign r_hs = (state == S_R) && rvalid;
  assign b_hs = (state == S_B) && bvalid;

  // Main control FSM. Requests are only taken in IDLE, so a d_req that the
  // cache is still holding during a transaction has no effect. Every valid
  // is decoded purely from the registered state, which keeps d_req off any
  // combinational path to the bus and holds valids stable until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (d_req) state <= d_write ? S_AW : S_AR;
        S_AR:   if (arready) state <= S_R;
        S_R:    if (rvalid && rlast) state <= S_IDLE;
        S_AW:   if (awready) state <= S_W;
        S_W:    if (wready) state <= S_B;
        S_B:    if (bvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request payload is captured once on acceptance so address, data and
  // strobes cannot move while a valid is up, whatever the cache does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= 32'h0;
      din_r  <= 32'h0;
      type_r <= 4'h0;
    end else if ((state == S_IDLE) && d_req) begin
      addr_r <= d_addr;
      din_r  <= d_in;
      type_r <= d_type;
    end
  end

  // Beat counter for the line fill. The burst is terminated by RLAST, not by
  // the count, so a short burst from the slave still returns us to IDLE and
  // the next fill starts from beat 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= 2'd0;
    end else if (r_hs) begin
      if (rlast) beat_cnt <= 2'd0;
      else       beat_cnt <= beat_cnt + 2'd1;
    end
  end

  // Read address channel: always a full aligned 16-byte line.
  assign arid    = AXI_ID;
  assign araddr  = {addr_r[31:4], 4'h0};
  assign arlen   = 4'd3;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arvalid = (state == S_AR);

  // Read data is passed straight through; the cache qualifies it with the
  // mirrored handshake.
  assign rready   = (state == S_R);
  assign d_out    = rdata;
  assign rvalid_o = rvalid;
  assign rready_o = rready;

  // Write address/data: single beat, strobes are the inverse of the cache's
  // active-low byte enables. An all-zero strobe is still sent as a write.
  assign awid    = AXI_ID;
  assign awaddr  = addr_r;
  assign awlen   = 4'd0;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign awvalid = (state == S_AW);

  assign wdata  = din_r;
  assign wstrb  = ~type_r;
  assign wlast  = 1'b1;
  assign wvalid = (state == S_W);

  assign bready  = (state == S_B);
  assign wr_done = b_hs;

`ifdef L1D_AXI_ERR_FLAG_EN
  logic bus_err_r;

  // Sticky error flag: any non-OKAY response or a foreign ID on a completed
  // handshake sets it, and only reset clears it. Transactions still finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_r <= 1'b0;
    end else if ((r_hs && ((rresp != 2'b00) || (rid != AXI_ID))) ||
                 (b_hs && ((bresp != 2'b00) || (bid != AXI_ID)))) begin
      bus_err_r <= 1'b1;
    end
  end

  assign bus_err = bus_err_r;
`else
  logic unused_err_inputs;

  assign unused_err_inputs = ^{rid, rresp, bid, bresp};
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_l1d_axi_master.sv
// Directed testbench for l1d_axi_master: line fill, byte store, AR/R
// backpressure, reset in the middle of a burst, and the error flag (with its
// expectation following whether L1D_AXI_ERR_FLAG_EN is defined).

module tb_l1d_axi_master;

  localparam logic [3:0] ID = 4'd1;
`ifdef L1D_AXI_ERR_FLAG_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_write;
  logic [31:0] d_addr, d_in, d_out;
  logic [3:0]  d_type;
  logic        rvalid_o, rready_o, wr_done, bus_err;
  logic [3:0]  arid, arlen, awid, awlen, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [3:0]  wstrb;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;
  int beats;
  int k;
  logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  l1d_axi_master #(.AXI_ID(ID)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_in(d_in),
    .d_type(d_type), .d_out(d_out), .rvalid_o(rvalid_o), .rready_o(rready_o),
    .wr_done(wr_done), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled a further #1 later, well away from either edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one R-channel cycle with a clean response.
  task automatic applyStimulus(input logic v, input logic [31:0] data,
                               input logic last);
    rvalid = v;
    rdata  = data;
    rlast  = last;
    rid    = ID;
    rresp  = 2'b00;
  endtask

  initial begin
    rst = 1'b1; d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_in = '0;
    d_type = 4'hf; arready = 1'b0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bid = ID; bresp = 2'b00;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_rready", rready_o, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_wr_done", wr_done, 0);
    checkOutput("rst_bus_err", bus_err, 0);
    tick; tick;
    rst = 1'b0;
    tick;

    // ---------------- line fill ----------------
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0001_0024; arready = 1'b1;
    #1;
    checkOutput("fill_no_comb_arvalid", arvalid, 0);
    tick;
    checkOutput("fill_arvalid", arvalid, 1);
    checkOutput("fill_araddr", araddr, 32'h0001_0020);
    checkOutput("fill_arlen", arlen, 3);
    checkOutput("fill_arsize", arsize, 2);
    checkOutput("fill_arburst", arburst, 1);
    checkOutput("fill_arid", arid, ID);
    tick;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA0 + i, i == 3);
      #1;
      checkOutput("fill_d_out", d_out, 32'hA0 + i);
      checkOutput("fill_handshake", rvalid_o & rready_o, 1);
      tick;
    end
    d_req = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("fill_idle_rready", rready_o, 0);
    checkOutput("fill_idle_arvalid", arvalid, 0);
    tick;
    checkOutput("fill_no_reissue", arvalid, 0);

    // ---------------- byte store ----------------
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_8004;
    d_in = 32'hDEAD_BEEF; d_type = 4'b1100;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; bid = ID;
    tick;
    checkOutput("st_awvalid", awvalid, 1);
    checkOutput("st_awaddr", awaddr, 32'h0000_8004);
    checkOutput("st_awlen", awlen, 0);
    checkOutput("st_awsize", awsize, 2);
    checkOutput("st_wvalid_early", wvalid, 0);
    tick;
    checkOutput("st_wvalid", wvalid, 1);
    checkOutput("st_wdata", wdata, 32'hDEAD_BEEF);
    checkOutput("st_wstrb", wstrb, 4'b0011);
    checkOutput("st_wlast", wlast, 1);
    checkOutput("st_wr_done_early", wr_done, 0);
    tick;
    checkOutput("st_bready", bready, 1);
    checkOutput("st_wr_done", wr_done, 1);
    tick;
    d_req = 1'b0; bvalid = 1'b0;
    #1;
    checkOutput("st_wr_done_pulse", wr_done, 0);
    checkOutput("st_idle_bready", bready, 0);
    tick;

    // ---------------- backpressure ----------------
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_1234; d_type = 4'hf;
    arready = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_arvalid_hold", arvalid, 1);
      checkOutput("bp_araddr_hold", araddr, 32'h0000_1230);
      tick;
    end
    arready = 1'b1;
    tick;
    beats = 0; k = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(pat[i], 32'hB0 + k, pat[i] && (k == 3));
      #1;
      checkOutput("bp_rready", rready_o, 1);
      if (pat[i]) checkOutput("bp_d_out", d_out, 32'hB0 + k);
      if (rvalid_o && rready_o) beats++;
      if (pat[i]) k++;
      tick;
    end
    d_req = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("bp_beats", beats, 4);
    checkOutput("bp_idle_rready", rready_o, 0);
    tick;
    checkOutput("bp_no_extra_ar", arvalid, 0);

    // ---------------- reset mid-burst ----------------
    d_req = 1'b1; d_addr = 32'h0000_2000;
    tick;
    tick;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hE0 + i, 1'b0);
      tick;
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rready", rready_o, 0);
    checkOutput("mid_rst_arvalid", arvalid, 0);
    checkOutput("mid_rst_awvalid", awvalid, 0);
    checkOutput("mid_rst_wvalid", wvalid, 0);
    checkOutput("mid_rst_bready", bready, 0);
    d_req = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    d_req = 1'b1; d_addr = 32'h0000_3008;
    tick;
    checkOutput("re_arvalid", arvalid, 1);
    checkOutput("re_araddr", araddr, 32'h0000_3000);
    tick;
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hC0 + i, i == 3);
      #1;
      checkOutput("re_d_out", d_out, 32'hC0 + i);
      if (rvalid_o && rready_o) beats++;
      tick;
    end
    d_req = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("re_beats", beats, 4);
    checkOutput("re_idle_rready", rready_o, 0);
    checkOutput("pre_err_bus_err", bus_err, 0);
    tick;

    // ---------------- error flag / zero-strobe write ----------------
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_9000;
    d_in = 32'h1234_5678; d_type = 4'hf;
    bvalid = 1'b1; bresp = 2'b10; bid = ID;
    tick;
    checkOutput("err_awvalid", awvalid, 1);
    tick;
    checkOutput("err_wvalid", wvalid, 1);
    checkOutput("err_wstrb_zero", wstrb, 4'h0);
    tick;
    checkOutput("err_wr_done", wr_done, 1);
    tick;
    d_req = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    #1;
    checkOutput("err_wr_done_pulse", wr_done, 0);
    checkOutput("err_bus_err", bus_err, ERR_EXP);
    tick;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_4000;
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hD0 + i, i == 3);
      #1;
      checkOutput("err_fill_d_out", d_out, 32'hD0 + i);
      tick;
    end
    d_req = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("err_bus_err_sticky", bus_err, ERR_EXP);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
